// File: rtl/board_glue_pkg.sv
// Shared types and helpers for the NEEK board glue controller.
// Holds the sequencer state enum, counter sizing and default timings.
package board_glue_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    PHY_RST = 2'd1,
    SETTLE  = 2'd2,
    READY   = 2'd3
  } glue_state_e;

  localparam int DEF_NUM_BUTTONS       = 4;
  localparam int DEF_DEBOUNCE_CYCLES   = 500000;
  localparam int DEF_FLASH_RST_CYCLES  = 50;
  localparam int DEF_PHY_RST_CYCLES    = 500000;
  localparam int DEF_PHY_SETTLE_CYCLES = 50000;

  // Width of a down-counter able to hold (largest duration - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/board_glue_ctrl_button_debounce.sv
// Single button channel: 2-flop sync, polarity fix, stability counter.
// Ports: clk_i, rst_ni, en_i (press enable), btn_i (raw pin), level_o, press_o.
module button_debounce
  import board_glue_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int W =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  // Sync flops reset to the released pin level so reset exit
  // never looks like a press.
  localparam logic IDLE = ACTIVE_LOW;

  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         level_q, level_d;
  logic         press_q, press_d;
  logic         pressed;

  assign pressed = sync_q[1] ^ IDLE;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q == LAST) begin
        level_d = pressed;
        press_d = pressed & en_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{IDLE}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/board_glue_ctrl.sv
// Board glue: flash/PHY reset sequencing, sys_ready, debounced buttons.
// Ports: clk, reset_n, button_in, button_level, button_press,
// flash_reset_n, phy_reset_n, sys_ready, and phy_rst_req when
// BOARD_GLUE_PHY_SOFT_RST_EN is defined (READY -> PHY_RST retrigger).
module board_glue_ctrl
  import board_glue_pkg::*;
#(
  parameter int NUM_BUTTONS       = DEF_NUM_BUTTONS,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int FLASH_RST_CYCLES  = DEF_FLASH_RST_CYCLES,
  parameter int PHY_RST_CYCLES    = DEF_PHY_RST_CYCLES,
  parameter int PHY_SETTLE_CYCLES = DEF_PHY_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef BOARD_GLUE_PHY_SOFT_RST_EN
  input  logic                   phy_rst_req,
`endif
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic                   flash_reset_n,
  output logic                   phy_reset_n,
  output logic                   sys_ready
);

  localparam int CW = cnt_width(FLASH_RST_CYCLES,
                                PHY_RST_CYCLES,
                                PHY_SETTLE_CYCLES);
  localparam logic [CW-1:0] F_LD = CW'(FLASH_RST_CYCLES - 1);
  localparam logic [CW-1:0] P_LD = CW'(PHY_RST_CYCLES - 1);
  localparam logic [CW-1:0] S_LD = CW'(PHY_SETTLE_CYCLES - 1);

  // Async assert, synchronous 2-flop release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  glue_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // HOLD is entered by reset with the counter at 0, so the first
  // active cycle loads the HOLD duration instead of leaving.
  logic          armed_q;
  logic          flash_q, phy_q, rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        if (!armed_q) begin
          cnt_d = F_LD;
        end else if (cnt_q == '0) begin
          state_d = PHY_RST;
          cnt_d   = P_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PHY_RST: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = S_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY: begin
`ifdef BOARD_GLUE_PHY_SOFT_RST_EN
        if (phy_rst_req) begin
          state_d = PHY_RST;
          cnt_d   = P_LD;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      flash_q <= 1'b0;
      phy_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      flash_q <= (state_d != HOLD);
      phy_q   <= (state_d == SETTLE) || (state_d == READY);
      rdy_q   <= (state_d == READY);
    end
  end

  assign flash_reset_n = flash_q;
  assign phy_reset_n   = phy_q;
  assign sys_ready     = rdy_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .ACTIVE_LOW      (BUTTON_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (rdy_q),
      .btn_i   (button_in[i]),
      .level_o (button_level[i]),
      .press_o (button_press[i])
    );
  end

endmodule

// File: tb/tb_board_glue_ctrl.sv
// Bench for board_glue_ctrl: expected output changes are queued by
// the stimulus and matched by a monitor on every observed change.
module tb_board_glue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       phy_rst_req;
  logic [3:0] button_in;
  logic [3:0] button_level;
  logic [3:0] button_press;
  logic       flash_reset_n;
  logic       phy_reset_n;
  logic       sys_ready;

  always #5 clk = ~clk;

  board_glue_ctrl #(
    .NUM_BUTTONS       (4),
    .BUTTON_ACTIVE_LOW (1'b1),
    .DEBOUNCE_CYCLES   (8),
    .FLASH_RST_CYCLES  (3),
    .PHY_RST_CYCLES    (5),
    .PHY_SETTLE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
`ifdef BOARD_GLUE_PHY_SOFT_RST_EN
    .phy_rst_req   (phy_rst_req),
`endif
    .button_in     (button_in),
    .button_level  (button_level),
    .button_press  (button_press),
    .flash_reset_n (flash_reset_n),
    .phy_reset_n   (phy_reset_n),
    .sys_ready     (sys_ready)
  );

  typedef struct packed {
    logic       flash;
    logic       phy;
    logic       rdy;
    logic [3:0] lvl;
    logic [3:0] prs;
  } snap_t;

  typedef struct {
    int    e;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  snap_t cur;
  int    ecnt = 0;
  int    checks = 0;
  int    failures = 0;
  bit    done = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic push(input int e);
    exp_t r;
    r.e = e;
    r.s = cur;
    exp_q.push_back(r);
  endtask

  task automatic wait_to(input int e);
    do begin
      @(posedge clk);
      #1;
    end while (ecnt < e);
  endtask

  // Monitor: every change of the output vector consumes one record.
  snap_t snap, prev;
  bit    first = 1'b1;
  exp_t  r;
  int    ev = 0;

  always @(negedge clk) begin
    snap = {flash_reset_n, phy_reset_n, sys_ready,
            button_level, button_press};
    if (first || snap != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change edge=%0d got=%b",
                 ecnt, snap);
      end else begin
        r = exp_q.pop_front();
        if (r.e != ecnt || r.s != snap) begin
          failures++;
          $display("FAIL ev%0d edge=%0d got=%b want edge=%0d val=%b",
                   ev, ecnt, snap, r.e, r.s);
        end
      end
      ev++;
    end
    prev  = snap;
    first = 1'b0;
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_events got=%0d pending want=0",
                 exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  int base, b2, k, e0;

  initial begin
    reset_n     = 1'b1;
    button_in   = 4'hF;
    phy_rst_req = 1'b0;
    #1 reset_n  = 1'b0;
    cur = '0;
    push(1);

    // Power-on sequence: flash +5, phy +10, ready +14.
    wait_to(4);
    reset_n = 1'b1;
    base = ecnt + 1;
    cur.flash = 1'b1; push(base + 5);
    cur.phy   = 1'b1; push(base + 10);
    cur.rdy   = 1'b1; push(base + 14);

    // Clean press on button 2, held 20 cycles.
    wait_to(base + 20);
    k = ecnt;
    button_in[2] = 1'b0;
    cur.lvl[2] = 1'b1; cur.prs[2] = 1'b1; push(k + 10);
    cur.prs[2] = 1'b0; push(k + 11);
    wait_to(k + 20);
    button_in[2] = 1'b1;
    cur.lvl[2] = 1'b0; push(k + 30);
    wait_to(k + 35);

    // Bouncing button 0: never stable long enough.
    k = ecnt;
    for (int i = 0; i < 12; i++) begin
      button_in[0] = ~button_in[0];
      wait_to(k + 5 * (i + 1));
    end
    wait_to(ecnt + 12);

    // Full reset, then a one-cycle reset pulse inside PHY_RST.
    e0 = ecnt;
    reset_n = 1'b0;
    cur.flash = 1'b0; cur.phy = 1'b0; cur.rdy = 1'b0;
    push(e0);
    wait_to(e0 + 2);
    reset_n = 1'b1;
    base = e0 + 3;
    cur.flash = 1'b1; push(base + 5);
    wait_to(base + 7);
    reset_n = 1'b0;
    cur.flash = 1'b0; push(base + 7);
    wait_to(base + 8);
    reset_n = 1'b1;
    b2 = base + 9;

    // Restarted sequence with button 1 pressed before sys_ready.
    wait_to(b2 + 1);
    button_in[1] = 1'b0;
    cur.flash  = 1'b1; push(b2 + 5);
    cur.phy    = 1'b1; push(b2 + 10);
    cur.lvl[1] = 1'b1; push(b2 + 11);
    cur.rdy    = 1'b1; push(b2 + 14);
    wait_to(b2 + 20);
    button_in[1] = 1'b1;
    cur.lvl[1] = 1'b0; push(b2 + 30);
    wait_to(b2 + 35);

`ifdef BOARD_GLUE_PHY_SOFT_RST_EN
    // Soft PHY reset from READY; second request lands in SETTLE.
    k = ecnt;
    phy_rst_req = 1'b1;
    cur.phy = 1'b0; cur.rdy = 1'b0; push(k + 1);
    cur.phy = 1'b1; push(k + 6);
    cur.rdy = 1'b1; push(k + 10);
    wait_to(k + 1);
    phy_rst_req = 1'b0;
    wait_to(k + 6);
    phy_rst_req = 1'b1;
    wait_to(k + 7);
    phy_rst_req = 1'b0;
    wait_to(k + 20);
`endif

    wait_to(ecnt + 5);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_timeout got=no_summary want=summary");
    $fatal(1, "bench did not terminate");
  end

endmodule
